// File: rtl/trading_status_monitor.sv
// trading_status_monitor: status and telemetry block for the trading system top level.
//
// Counts per-channel events with saturating counters, stretches event strobes into LED
// activity pulses, tracks a position-nonzero flag and the peak |position|, generates a
// heartbeat, and offers an atomic snapshot (optionally clearing live state) with indexed
// readout of the captured shadow registers.
//
// Ports:
//   clk_sys          system clock, rising edge
//   rstn             synchronous active-low reset
//   event_in         per-channel one-cycle event strobes
//   position_in      signed position, sampled every cycle
//   snap_req         snapshot request strobe
//   snap_clear       with snap_req: clear live counters and peak when snapshotting
//   snap_ack         one-cycle pulse once the snapshot is captured
//   rd_en, rd_idx    read strobe and index (NUM_CH selects the peak shadow)
//   rd_data          read data, held between reads
//   rd_valid         one-cycle pulse qualifying rd_data
//   activity_out     stretched per-channel activity
//   position_nonzero registered (position_in != 0)
//   heartbeat        square wave, period 2*HB_CYC
//   status_leds      {heartbeat, position_nonzero, 0.., activity_out}
module trading_status_monitor #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned POS_W       = 32,
  parameter int unsigned STRETCH_CYC = 1000000,
  parameter int unsigned HB_CYC      = 50000000
) (
  input  logic                             clk_sys,
  input  logic                             rstn,
  input  logic [NUM_CH-1:0]                event_in,
  input  logic [POS_W-1:0]                 position_in,
  input  logic                             snap_req,
  input  logic                             snap_clear,
  output logic                             snap_ack,
  input  logic                             rd_en,
  input  logic [$clog2(NUM_CH+1)-1:0]      rd_idx,
  output logic [CNT_W-1:0]                 rd_data,
  output logic                             rd_valid,
  output logic [NUM_CH-1:0]                activity_out,
  output logic                             position_nonzero,
  output logic                             heartbeat,
  output logic [7:0]                       status_leds
);

  localparam int unsigned IdxW = $clog2(NUM_CH + 1);
  localparam int unsigned StW  = $clog2(STRETCH_CYC + 1);
  localparam int unsigned HbW  = (HB_CYC > 1) ? $clog2(HB_CYC) : 1;

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   live_q   [NUM_CH];
  logic [CNT_W-1:0]   live_d   [NUM_CH];
  logic [CNT_W-1:0]   shadow_q [NUM_CH];
  logic [CNT_W-1:0]   shadow_d [NUM_CH];
  logic [CNT_W-1:0]   live_inc [NUM_CH];
  logic [StW-1:0]     st_q     [NUM_CH];
  logic [StW-1:0]     st_d     [NUM_CH];
  logic [POS_W-1:0]   peak_q, peak_d, shadow_peak_q, shadow_peak_d;
  logic [POS_W-1:0]   mag, peak_max;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [NUM_CH-1:0]  act_q, act_d;
  logic               pnz_q, pnz_d;
  logic [HbW-1:0]     hb_cnt_q, hb_cnt_d;
  logic               hb_q, hb_d;
  logic               snap_take;

  always_comb begin
    // Two's-complement negate; the most negative value maps to 2^(POS_W-1) unsigned.
    mag       = position_in[POS_W-1] ? (~position_in + POS_W'(1)) : position_in;
    peak_max  = (mag > peak_q) ? mag : peak_q;
    snap_take = (state_q == StIdle) && snap_req;

    for (int i = 0; i < NUM_CH; i++) begin
      live_inc[i] = (event_in[i] && (live_q[i] != '1)) ? live_q[i] + CNT_W'(1) : live_q[i];
    end

    state_d       = snap_take ? StAck : StIdle;
    live_d        = live_inc;
    peak_d        = peak_max;
    shadow_d      = shadow_q;
    shadow_peak_d = shadow_peak_q;
    if (snap_take) begin
      shadow_d      = live_inc;
      shadow_peak_d = peak_max;
      if (snap_clear) begin
        for (int i = 0; i < NUM_CH; i++) live_d[i] = '0;
        peak_d = '0;
      end
    end

    // Reads see the shadow as it was at the start of the cycle.
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_idx == IdxW'(i)) rd_data_d = shadow_q[i];
      end
      if (rd_idx == IdxW'(NUM_CH)) rd_data_d = CNT_W'(shadow_peak_q);
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (event_in[i])         st_d[i] = StW'(STRETCH_CYC);
      else if (st_q[i] != '0)  st_d[i] = st_q[i] - StW'(1);
      else                     st_d[i] = '0;
      act_d[i] = (st_d[i] != '0);
    end

    pnz_d = |position_in;

    if (hb_cnt_q == HbW'(HB_CYC - 1)) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end else begin
      hb_cnt_d = hb_cnt_q + HbW'(1);
      hb_d     = hb_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rstn) begin
      state_q       <= StIdle;
      peak_q        <= '0;
      shadow_peak_q <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      act_q         <= '0;
      pnz_q         <= 1'b0;
      hb_cnt_q      <= '0;
      hb_q          <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
        st_q[i]     <= '0;
      end
    end else begin
      state_q       <= state_d;
      peak_q        <= peak_d;
      shadow_peak_q <= shadow_peak_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      act_q         <= act_d;
      pnz_q         <= pnz_d;
      hb_cnt_q      <= hb_cnt_d;
      hb_q          <= hb_d;
      for (int i = 0; i < NUM_CH; i++) begin
        live_q[i]   <= live_d[i];
        shadow_q[i] <= shadow_d[i];
        st_q[i]     <= st_d[i];
      end
    end
  end

  assign snap_ack         = (state_q == StAck);
  assign rd_data          = rd_data_q;
  assign rd_valid         = rd_valid_q;
  assign activity_out     = act_q;
  assign position_nonzero = pnz_q;
  assign heartbeat        = hb_q;

  always_comb begin
    status_leds             = '0;
    status_leds[NUM_CH-1:0] = act_q;
    status_leds[6]          = pnz_q;
    status_leds[7]          = hb_q;
  end

endmodule

// File: tb/tb_trading_status_monitor.sv
// Scoreboard bench for trading_status_monitor: the stimulus process updates a behavioural
// model and queues the outputs expected after each clock edge; a monitor process pops
// and compares them.
module tb_trading_status_monitor;

  localparam int NCH   = 4;
  localparam int CW    = 8;
  localparam int PW    = 8;
  localparam int SCYC  = 4;
  localparam int HCYC  = 8;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NCH-1:0]   event_in = '0;
  logic [PW-1:0]    position_in = '0;
  logic             snap_req = 1'b0;
  logic             snap_clear = 1'b0;
  logic             snap_ack;
  logic             rd_en = 1'b0;
  logic [2:0]       rd_idx = '0;
  logic [CW-1:0]    rd_data;
  logic             rd_valid;
  logic [NCH-1:0]   activity_out;
  logic             position_nonzero;
  logic             heartbeat;
  logic [7:0]       status_leds;

  trading_status_monitor #(
    .NUM_CH(NCH), .CNT_W(CW), .POS_W(PW), .STRETCH_CYC(SCYC), .HB_CYC(HCYC)
  ) dut (
    .clk_sys(clk), .rstn(rstn), .event_in(event_in), .position_in(position_in),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_ack(snap_ack),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .activity_out(activity_out), .position_nonzero(position_nonzero),
    .heartbeat(heartbeat), .status_leds(status_leds)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] act;
    logic           pnz;
    logic           hb;
    logic           ack;
    logic           rv;
    logic [CW-1:0]  rd;
    logic [7:0]     leds;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Behavioural model state (plain integers).
  int m_live[NCH];
  int m_shadow[NCH];
  int m_peak, m_shpeak, m_rd, m_hbk, m_edge;
  int m_last[NCH];
  bit m_in_ack, m_pnz;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_live[i] = 0; m_shadow[i] = 0; m_last[i] = -1000;
    end
    m_peak = 0; m_shpeak = 0; m_rd = 0; m_hbk = 0; m_in_ack = 0; m_pnz = 0;
  endtask

  // Predict the outputs visible after the coming rising edge.
  task automatic model_step();
    exp_t e;
    int   p, mag, np;
    int   nl[NCH];
    bit   acc;
    e = '0;
    if (!rstn) begin
      model_reset();
    end else begin
      p   = int'($signed(position_in));
      mag = (p < 0) ? -p : p;
      acc = snap_req && !m_in_ack;
      m_in_ack = acc;
      e.ack = acc;
      e.rv  = rd_en;
      if (rd_en) begin
        if (rd_idx < NCH)       m_rd = m_shadow[rd_idx];
        else if (rd_idx == NCH) m_rd = m_shpeak;
        else                    m_rd = 0;
      end
      for (int i = 0; i < NCH; i++) begin
        nl[i] = m_live[i] + int'(event_in[i]);
        if (nl[i] > CMAX) nl[i] = CMAX;
        if (event_in[i]) m_last[i] = m_edge;
      end
      np = (mag > m_peak) ? mag : m_peak;
      if (acc) begin
        for (int i = 0; i < NCH; i++) m_shadow[i] = nl[i];
        m_shpeak = np;
      end
      if (acc && snap_clear) begin
        for (int i = 0; i < NCH; i++) m_live[i] = 0;
        m_peak = 0;
      end else begin
        for (int i = 0; i < NCH; i++) m_live[i] = nl[i];
        m_peak = np;
      end
      m_pnz = (p != 0);
      m_hbk++;
    end
    for (int i = 0; i < NCH; i++) e.act[i] = (m_edge - m_last[i]) < SCYC;
    e.pnz  = m_pnz;
    e.hb   = ((m_hbk / HCYC) % 2) == 1;
    e.rd   = CW'(m_rd);
    e.leds = {e.hb, e.pnz, 2'b00, e.act};
    m_edge++;
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [NCH-1:0] ev, input int pos,
                       input logic sr, input logic sc, input logic re, input logic [2:0] idx);
    @(negedge clk);
    rstn = r; event_in = ev; position_in = PW'(pos);
    snap_req = sr; snap_clear = sc; rd_en = re; rd_idx = idx;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, '0, 0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every cycle's outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("activity_out", 32'(activity_out), 32'(e.act));
        chk("position_nonzero", 32'(position_nonzero), 32'(e.pnz));
        chk("heartbeat", 32'(heartbeat), 32'(e.hb));
        chk("snap_ack", 32'(snap_ack), 32'(e.ack));
        chk("rd_valid", 32'(rd_valid), 32'(e.rv));
        chk("rd_data", 32'(rd_data), 32'(e.rd));
        chk("status_leds", 32'(status_leds), 32'(e.leds));
      end
    end
  end

  initial begin
    m_edge = 0;
    model_reset();
    repeat (3) drive(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(2);

    // Activity stretch and retrigger on channel 1.
    drive(1'b1, 4'b0010, 0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(6);
    drive(1'b1, 4'b0010, 0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(1);
    drive(1'b1, 4'b0010, 0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(8);

    // Saturation of channel 0.
    repeat (300) drive(1'b1, 4'b0001, 0, 1'b0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, '0, 0, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(1);
    drive(1'b1, '0, 0, 1'b0, 1'b0, 1'b1, 3'd0);
    idle(1);

    // Clearing snapshot includes the same-cycle event.
    drive(1'b1, '0, 0, 1'b1, 1'b1, 1'b0, 3'd0);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'b0100, 0, 1'b0, 1'b0, 1'b0, 3'd0);
      idle(1);
    end
    drive(1'b1, 4'b0100, 0, 1'b1, 1'b1, 1'b0, 3'd0);
    idle(1);
    drive(1'b1, '0, 0, 1'b0, 1'b0, 1'b1, 3'd2);
    drive(1'b1, '0, 0, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(1);
    drive(1'b1, '0, 0, 1'b0, 1'b0, 1'b1, 3'd2);
    idle(1);

    // Peak tracking, including the most negative position.
    drive(1'b1, '0, 5, 1'b0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, '0, -20, 1'b0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, '0, 7, 1'b0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, '0, 0, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(1);
    drive(1'b1, '0, 0, 1'b0, 1'b0, 1'b1, 3'd4);
    drive(1'b1, '0, -128, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(1);
    drive(1'b1, '0, 0, 1'b0, 1'b0, 1'b1, 3'd4);
    idle(1);

    // Back-to-back requests, read colliding with snapshot, out-of-range index.
    drive(1'b1, 4'b1000, 3, 1'b1, 1'b0, 1'b1, 3'd3);
    drive(1'b1, 4'b1000, 3, 1'b1, 1'b0, 1'b1, 3'd3);
    drive(1'b1, '0, 0, 1'b0, 1'b0, 1'b1, 3'd7);
    idle(2);

    // Reset with a request pending, and the cycle after a request.
    drive(1'b1, 4'b1111, 9, 1'b1, 1'b0, 1'b1, 3'd1);
    drive(1'b0, 4'b1111, 9, 1'b0, 1'b0, 1'b1, 3'd1);
    idle(3);
    drive(1'b0, 4'b0001, 9, 1'b1, 1'b0, 1'b1, 3'd0);
    idle(20);

    // Randomised traffic.
    for (int k = 0; k < 2000; k++) begin
      logic [NCH-1:0] ev;
      int pos;
      for (int i = 0; i < NCH; i++) ev[i] = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       pos = 0;
        1:       pos = -128;
        2:       pos = 127;
        default: pos = int'($signed(8'($urandom)));
      endcase
      drive($urandom_range(0, 199) != 0, ev, pos, $urandom_range(0, 5) == 0,
            1'($urandom), $urandom_range(0, 2) == 0, 3'($urandom));
    end
    idle(4);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
